mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port 64x14 pixel/coefficient memory between NREQ requesters
//  (host config port, DSP core, pixel path), replacing the fixed single-owner hookup.
//  Round-robin arbitration with burst hold and a burst limit.
//  Registered grants; 1-cycle memory read latency; read data returned per requester.
// PARAMETERS
//  NREQ      3   number of requesters (2..4)
//  AW        6   memory address width
//  DW        14  memory data width
//  MAXBURST  8   max consecutive accesses per grant when others are pending (1..15)
// PORTS
//  clk       in   1        single clock, all logic on posedge
//  rstn      in   1        synchronous reset, active-low
//  req       in   NREQ     access request per requester, held for the whole burst
//  we        in   NREQ     1=write, 0=read, per requester
//  addr      in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  wdata     in   NREQ*DW  packed write data, requester i at [i*DW +: DW]
//  gnt       out  NREQ     one-hot grant (registered)
//  rvalid    out  NREQ     one-hot read-data-valid (registered)
//  rdata     out  DW       read data, shared, qualified by rvalid
//  mem_cs    out  1        memory chip select
//  mem_we    out  1        memory write enable
//  mem_addr  out  AW       memory address
//  mem_din   out  DW       memory write data
//  mem_dout  in   DW       memory read data, valid 1 cycle after read cs
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): state=IDLE, gnt=0, rvalid=0, rr_ptr=0, burst_cnt=0.
//    An in-flight read is dropped; rvalid stays 0 the cycle after reset.
//  - FSM IDLE: if any req, winner = first set req at or after rr_ptr (wrapping NREQ-1->0).
//    gnt[winner] is set next cycle; state moves to BUSY; burst_cnt=0.
//  - FSM BUSY: each cycle with gnt[i]&req[i] is one access. Combinationally:
//    mem_cs=1, mem_we=we[i], mem_addr/mem_din from slot i; burst_cnt++.
//  - BUSY -> IDLE with gnt=0 and rr_ptr=i+1 (mod NREQ) when:
//    (a) req[i]=0 (no access that cycle, mem_cs=0); or
//    (b) the access makes burst_cnt==MAXBURST and any other req is high.
//    With no other requester, the burst continues unlimited; burst_cnt saturates.
//  - Arbitration cost: 1 idle cycle between grants (IDLE cycle), not back-to-back.
//  - Read: access in cycle N -> rvalid[i]=1, rdata=mem_dout in cycle N+1. rvalid may
//    coincide with gnt change/new grant. rdata holds its last value when rvalid=0.
//  - Write: completes in the access cycle; no response.
//  - mem_cs=0 whenever gnt=0; at most one gnt bit and one rvalid bit set.
//  - req dropped mid-burst: that cycle issues no access; reads already issued still
//    return rvalid.
// CONFIGURATION
//  MEM_ARB_PRIO_EN defined: requester 0 (host) has absolute priority in IDLE.
//    While another requester holds the grant and req[0] is high, the burst is cut
//    after the current access, regardless of MAXBURST.
//    rr_ptr is used only among requesters 1..NREQ-1 and is not advanced by grants to 0.
//  Not defined: pure round-robin as above; requester 0 has no special treatment.
// TESTING
//  1 Reset: rstn=0 for 2 clks with req=3'b111 -> gnt=0, rvalid=0, mem_cs=0 throughout;
//    first grant after release goes to req0.
//  2 Single read: req[1]=1, addr1=6'h2A, mem model holds 14'h1234 -> gnt=3'b010 one cycle
//    later, mem_addr=6'h2A, mem_cs=1, mem_we=0; next cycle rvalid=3'b010, rdata=14'h1234.
//  3 Round robin: req=3'b111, each single access then drop -> grant order 0,1,2,0,
//    one idle cycle between grants.
//  4 Burst limit: req0 and req2 held high, MAXBURST=8 -> gnt[0] for exactly 8 accesses,
//    then 1 idle cycle, then gnt[2]. Req0 held alone -> >8 consecutive accesses.
//  5 Write/read-back: req2 writes 14'h3FFF to 6'h3F, then reads 6'h3F ->
//    rvalid[2]=1, rdata=14'h3FFF.
//  6 Reset mid-read: rstn=0 in the cycle after a read access -> no rvalid, gnt=0 next
//    cycle. With MEM_ARB_PRIO_EN: req0 raised during req1 burst -> gnt[1] drops
//    after the current access, then gnt[0] after the idle cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between NREQ requesters.
//   Round-robin arbitration, burst hold while req stays high, burst cut at
//   MAXBURST accesses when another requester is waiting. One idle cycle
//   separates consecutive grants. Reads return one cycle after the access.
// Optional build macro:
//   MEM_ARB_PRIO_EN - requester 0 wins every arbitration and cuts any other
//                     requester's burst after its current access.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   req/we             per-requester request and write enable
//   addr/wdata         packed per-requester address and write data
//   gnt                one-hot grant (registered)
//   rvalid             one-hot read-data-valid (registered)
//   rdata              shared read data, held while rvalid is low
//   mem_cs/mem_we      memory strobes, driven by the granted requester
//   mem_addr/mem_din   memory address and write data
//   mem_dout           memory read data, one cycle after a read strobe
module mem_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned AW       = 6,
  parameter int unsigned DW       = 14,
  parameter int unsigned MAXBURST = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_cs,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_din,
  input  logic [DW-1:0]      mem_dout
);

  localparam int unsigned PW = (NREQ > 2) ? 2 : 1;
  localparam int unsigned CW = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]      state, state_n;
  logic [NREQ-1:0] gnt_n, rvalid_n;
  logic [PW-1:0]   rr_ptr, rr_ptr_n, cur, win, idx, cur_inc;
  logic [CW-1:0]   burst_cnt, burst_cnt_n, cnt_inc;
  logic [DW-1:0]   rdata_q;
  logic            found, access, others, cut;

  // Route the granted requester's slot to the memory.
  always_comb begin
    cur      = '0;
    mem_addr = '0;
    mem_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        cur      = PW'(i);
        mem_addr = addr[i*AW +: AW];
        mem_din  = wdata[i*DW +: DW];
      end
    end
    access = (state == BUSY) && (|(gnt & req));
    mem_cs = access;
    mem_we = access & we[cur];
  end

  // Winner search: first request at or after rr_ptr, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((32'(rr_ptr) + 32'(k)) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef MEM_ARB_PRIO_EN
    if (req[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
  end

  // Next state, grant, pointer and burst bookkeeping.
  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    rr_ptr_n    = rr_ptr;
    burst_cnt_n = burst_cnt;
    rvalid_n    = '0;

    cur_inc = (32'(cur) + 32'd1 == NREQ) ? '0 : cur + PW'(1);
    // Saturates so an unlimited lone burst still trips the cut when others arrive.
    cnt_inc = (burst_cnt >= CW'(MAXBURST)) ? burst_cnt : burst_cnt + CW'(1);
    others  = |(req & ~gnt);
    cut     = (cnt_inc == CW'(MAXBURST)) && others;
`ifdef MEM_ARB_PRIO_EN
    if (req[0] && !gnt[0]) cut = 1'b1;
`endif

    case (state)
      IDLE: begin
        if (found) begin
          state_n     = BUSY;
          gnt_n       = NREQ'(1) << win;
          burst_cnt_n = '0;
        end
      end
      BUSY: begin
        if (!access || cut) begin
          state_n  = IDLE;
          gnt_n    = '0;
          rr_ptr_n = cur_inc;
`ifdef MEM_ARB_PRIO_EN
          // Host grants do not disturb rotation among the other requesters.
          if (cur == '0) rr_ptr_n = rr_ptr;
`endif
        end
        if (access) begin
          burst_cnt_n = cnt_inc;
          if (!we[cur]) rvalid_n = NREQ'(1) << cur;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // State registers; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      gnt       <= '0;
      rvalid    <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      rdata_q   <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      rvalid    <= rvalid_n;
      rr_ptr    <= rr_ptr_n;
      burst_cnt <= burst_cnt_n;
      rdata_q   <= rdata;
    end
  end

  // Memory output is only meaningful in the rvalid cycle; otherwise hold.
  assign rdata = (|rvalid) ? mem_dout : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed stimulus, read responses checked by a
// scoreboard queue drained by an independent negedge monitor.
module tb_mem_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 6;
  localparam int unsigned DW   = 14;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ-1:0]    req, we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt, rvalid;
  logic [DW-1:0]      rdata;
  logic               mem_cs, mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_din, mem_dout;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } rd_t;

  rd_t  exp_q[$];
  rd_t  mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [DW-1:0] mem [64];

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAXBURST(8)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Single-port memory, 1-cycle read latency; known contents loaded in reset.
  always @(posedge clk) begin
    if (!rstn) begin
      mem[6'h2A] <= 14'h1234;
      mem[6'h05] <= 14'h0ABC;
      mem[6'h11] <= 14'h2222;
    end else if (mem_cs) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      else        mem_dout      <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rvalid != '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: rvalid=%b, expected no response", rvalid);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_valid", 32'(rvalid), 32'(3'b001 << mon_e.id));
        chk("rd_data", 32'(rdata), 32'(mon_e.data));
      end
    end
    chk("onehot", 32'({$onehot0(gnt), $onehot0(rvalid)}), 32'(2'b11));
  end

  task automatic push_rd(input int i, input logic [DW-1:0] d);
    rd_t e;
    e.id   = 2'(i);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic set_slot(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i]               = w;
    addr[i*AW +: AW]    = a;
    wdata[i*DW +: DW]   = d;
  endtask

  // Waits (bounded) for any grant, then checks it.
  task automatic wait_gnt(input string name, input logic [2:0] exp);
    int n = 0;
    while (gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(gnt), 32'(exp));
  endtask

  // One access by requester i from IDLE; d is write data or expected read data.
  task automatic single(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input string name);
    set_slot(i, w, a, d);
    req[i] = 1'b1;
    @(negedge clk);
    wait_gnt({name, "_gnt"}, 3'(1 << i));
    if (!w) push_rd(i, d);
    @(negedge clk);
    req[i] = 1'b0;
    @(negedge clk);
    chk({name, "_release"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    int ord [4];
    logic [DW-1:0] dat [4];

    // Reset held with all requests high.
    rstn = 1'b0; req = 3'b111; we = '0; addr = '0; wdata = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t1_rst_gnt", 32'(gnt), 32'd0);
      chk("t1_rst_rvalid", 32'(rvalid), 32'd0);
      chk("t1_rst_cs", 32'(mem_cs), 32'd0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("t1_first_gnt", 32'(gnt), 32'(3'b001));
    chk("t1_first_cs", 32'(mem_cs), 32'd1);
    req = '0;
    @(negedge clk);
    chk("t1_release", 32'(gnt), 32'd0);

    // Single read by requester 1.
    set_slot(1, 1'b0, 6'h2A, '0);
    req = 3'b010;
    @(negedge clk);
    wait_gnt("t2_gnt", 3'b010);
    chk("t2_addr", 32'(mem_addr), 32'(6'h2A));
    chk("t2_cs", 32'(mem_cs), 32'd1);
    chk("t2_we", 32'(mem_we), 32'd0);
    push_rd(1, 14'h1234);
    @(negedge clk);
    chk("t2_rvalid", 32'(rvalid), 32'(3'b010));
    chk("t2_rdata", 32'(rdata), 32'(14'h1234));
    req = '0;
    @(negedge clk);
    chk("t2_release", 32'(gnt), 32'd0);
    chk("t2_rdata_hold", 32'(rdata), 32'(14'h1234));

    // Write then read back from requester 2.
    single(2, 1'b1, 6'h3F, 14'h3FFF, "t5_wr");
    single(2, 1'b0, 6'h3F, 14'h3FFF, "t5_rd");

`ifndef MEM_ARB_PRIO_EN
    // Round robin with one access per grant.
    set_slot(0, 1'b0, 6'h05, '0);
    set_slot(1, 1'b0, 6'h2A, '0);
    set_slot(2, 1'b0, 6'h11, '0);
    ord = '{0, 1, 2, 0};
    dat = '{14'h0ABC, 14'h1234, 14'h2222, 14'h0ABC};
    req = 3'b111;
    @(negedge clk);
    for (int it = 0; it < 4; it++) begin
      chk("t3_gnt_order", 32'(gnt), 32'(3'b001 << ord[it]));
      push_rd(ord[it], dat[it]);
      @(negedge clk);
      req[ord[it]] = 1'b0;
      @(negedge clk);
      chk("t3_idle_gnt", 32'(gnt), 32'd0);
      chk("t3_idle_cs", 32'(mem_cs), 32'd0);
      if (it < 3) req[ord[it]] = 1'b1;
      else        req = '0;
      @(negedge clk);
    end

    // Park the pointer on requester 0 for the burst test.
    single(2, 1'b0, 6'h11, 14'h2222, "t4_pre");

    // Burst limit with requester 2 waiting.
    set_slot(0, 1'b0, 6'h05, '0);
    set_slot(2, 1'b0, 6'h11, '0);
    req = 3'b101;
    @(negedge clk);
    wait_gnt("t4_gnt0", 3'b001);
    cnt = 0;
    n = 0;
    while (gnt == 3'b001 && n < 30) begin
      push_rd(0, 14'h0ABC);
      cnt++;
      n++;
      @(negedge clk);
    end
    chk("t4_burst_len", 32'(cnt), 32'd8);
    chk("t4_idle", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("t4_gnt2", 32'(gnt), 32'(3'b100));
    req = 3'b001;
    @(negedge clk);
    chk("t4_rel2", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("t4_gnt0_alone", 32'(gnt), 32'(3'b001));
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (gnt == 3'b001) begin
        cnt++;
        push_rd(0, 14'h0ABC);
      end
      @(negedge clk);
    end
    chk("t4_unlimited_len", 32'(cnt), 32'd12);
    req = '0;
    @(negedge clk);
    chk("t4_release", 32'(gnt), 32'd0);
`endif

    // Reset lands on the edge completing a read: response is dropped.
    set_slot(1, 1'b0, 6'h2A, '0);
    req = 3'b010;
    @(negedge clk);
    wait_gnt("t6_gnt", 3'b010);
    rstn = 1'b0;
    @(negedge clk);
    chk("t6_rst_gnt", 32'(gnt), 32'd0);
    chk("t6_rst_rvalid", 32'(rvalid), 32'd0);
    chk("t6_rst_cs", 32'(mem_cs), 32'd0);
    rstn = 1'b1;
    req = '0;
    @(negedge clk);
    chk("t6_post_rvalid", 32'(rvalid), 32'd0);
    chk("t6_post_gnt", 32'(gnt), 32'd0);

`ifdef MEM_ARB_PRIO_EN
    // Host request cuts requester 1's burst after the current access.
    set_slot(0, 1'b0, 6'h05, '0);
    set_slot(1, 1'b0, 6'h2A, '0);
    req = 3'b010;
    @(negedge clk);
    wait_gnt("t6p_gnt1", 3'b010);
    push_rd(1, 14'h1234);
    @(negedge clk);
    push_rd(1, 14'h1234);
    @(negedge clk);
    push_rd(1, 14'h1234);
    req = 3'b011;
    @(negedge clk);
    chk("t6p_cut", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("t6p_gnt0", 32'(gnt), 32'(3'b001));
    push_rd(0, 14'h0ABC);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("t6p_release", 32'(gnt), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
